// File: rtl/pipeline_pkg.sv
`default_nettype none
// ==== pipeline_pkg : port indices, FSM states and helpers for pipeline_one_sched ==== rev 1.0
package pipeline_pkg;

  localparam int P_N            = 0;
  localparam int P_S            = 1;
  localparam int P_E            = 2;
  localparam int P_W            = 3;
  localparam int P_L            = 4;
  localparam int NPORTS         = 5;
  localparam int DATA_W_DEFAULT = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    GAP    = 2'd3
  } sched_state_e;

  // Port index modulo 5; callers never pass anything above 9.
  function automatic logic [2:0] wrap5(input int v);
    if (v >= NPORTS) return 3'(v - NPORTS);
    return 3'(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_one_sched_if.sv
`default_nettype none
// ==== pipeline_one_sched_if : requester handshake and pipeline_one load bus ==== rev 1.0
interface pipeline_one_sched_if
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
);

  logic [NPORTS-1:0] req;
  logic [DATA_W-1:0] data_n;
  logic [DATA_W-1:0] data_s;
  logic [DATA_W-1:0] data_e;
  logic [DATA_W-1:0] data_w;
  logic [DATA_W-1:0] data_l;
  logic [NPORTS-1:0] ack;
  logic [DATA_W-1:0] inc;
  logic              nsig;
  logic              ssig;
  logic              esig;
  logic              wsig;
  logic              lsig;
  logic              commit;
  logic              busy;
  logic [NPORTS-1:0] round_mask;

  modport master (
    output req, data_n, data_s, data_e, data_w, data_l,
    input  ack, inc, nsig, ssig, esig, wsig, lsig, commit, busy, round_mask
  );

  modport slave (
    input  req, data_n, data_s, data_e, data_w, data_l,
    output ack, inc, nsig, ssig, esig, wsig, lsig, commit, busy, round_mask
  );

endinterface
`default_nettype wire

// File: rtl/pipeline_one_sched_rr_pick5.sv
`default_nettype none
// ==== rr_pick5 : first eligible port scanning upward from ptr, wrapping L->N ==== rev 1.0
module rr_pick5
  import pipeline_pkg::*;
(
  input  logic [NPORTS-1:0] eligible_i,
  input  logic [2:0]        ptr_i,
  output logic [NPORTS-1:0] onehot_o,
  output logic [2:0]        idx_o
);

  logic       found;
  logic [2:0] cand;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 0; k < NPORTS; k++) begin
      cand = wrap5(int'(ptr_i) + k);
      if (!found && eligible_i[cand]) begin
        found          = 1'b1;
        onehot_o[cand] = 1'b1;
        idx_o          = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_one_sched.sv
`default_nettype none
// ==== pipeline_one_sched : round-robin 5-port scheduler serialising flits onto pipeline_one ==== rev 1.0
module pipeline_one_sched
  import pipeline_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int TIMEOUT = 8
) (
  input  logic                clksig,
  input  logic                rstsig,
  pipeline_one_sched_if.slave sif
);

  localparam int               TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

  sched_state_e      state_q;
  logic [2:0]        ptr_q;
  logic [2:0]        ptr_d;
  logic [NPORTS-1:0] served_q;
  logic [NPORTS-1:0] eligible;
  logic [NPORTS-1:0] grant_oh;
  logic [2:0]        grant_idx;
  logic              grant_en;
  logic [NPORTS-1:0] strb_q;
  logic [NPORTS-1:0] ack_q;
  logic [TMR_W-1:0]  timer_q;
  logic [DATA_W-1:0] inc_q;
  logic [DATA_W-1:0] inc_d;
  logic              commit_q;
  logic              busy_q;

  assign eligible = sif.req & ~served_q;
  assign grant_en = ((state_q == IDLE) || (state_q == LOAD)) && (|eligible);
  assign ptr_d    = wrap5(int'(grant_idx) + 1);

  rr_pick5 u_pick (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .onehot_o   (grant_oh),
    .idx_o      (grant_idx)
  );

  always_comb begin
    case (grant_idx)
      3'd1:    inc_d = sif.data_s;
      3'd2:    inc_d = sif.data_e;
      3'd3:    inc_d = sif.data_w;
      3'd4:    inc_d = sif.data_l;
      default: inc_d = sif.data_n;
    endcase
  end

  // Strobe/ack/inc default to zero every cycle; a grant overrides them for one cycle.
  always_ff @(posedge clksig or posedge rstsig) begin
    if (rstsig) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      served_q <= '0;
      timer_q  <= '0;
      strb_q   <= '0;
      ack_q    <= '0;
      inc_q    <= '0;
      commit_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      strb_q   <= '0;
      ack_q    <= '0;
      inc_q    <= '0;
      commit_q <= 1'b0;

      if (grant_en) begin
        strb_q   <= grant_oh;
        ack_q    <= grant_oh;
        inc_q    <= inc_d;
        served_q <= served_q | grant_oh;
        ptr_q    <= ptr_d;
        timer_q  <= '0;
      end

      case (state_q)
        IDLE: begin
          if (grant_en) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          // A pending grant always wins over commit so the last strobe never meets commit.
          if (!grant_en) begin
            if ((served_q == '1) || ((timer_q == TMR_LAST) && (served_q != '0))) begin
              state_q  <= COMMIT;
              commit_q <= 1'b1;
            end else if (timer_q != TMR_MAX) begin
              timer_q <= timer_q + TMR_W'(1);
            end
          end
        end
        COMMIT: begin
          state_q <= GAP;
        end
        GAP: begin
          served_q <= '0;
          timer_q  <= '0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sif.ack        = ack_q;
  assign sif.inc        = inc_q;
  assign sif.nsig       = strb_q[P_N];
  assign sif.ssig       = strb_q[P_S];
  assign sif.esig       = strb_q[P_E];
  assign sif.wsig       = strb_q[P_W];
  assign sif.lsig       = strb_q[P_L];
  assign sif.commit     = commit_q;
  assign sif.busy       = busy_q;
  assign sif.round_mask = served_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_one_sched.sv
`default_nettype none
// ==== tb_pipeline_one_sched : scoreboard bench for the round-robin scheduler ==== rev 1.0
module tb_pipeline_one_sched;
  import pipeline_pkg::*;

  localparam int DW = 7;

  typedef struct {
    int            cyc;
    logic [4:0]    strb;
    logic [4:0]    ack;
    logic [DW-1:0] inc;
    logic          commit;
  } ev_t;

  logic clksig = 1'b0;
  logic rstsig = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  ev_t  exp_q[$];

  always #5 clksig = ~clksig;
  always @(posedge clksig) cyc <= cyc + 1;

  pipeline_one_sched_if #(.DATA_W(DW)) sif ();

  pipeline_one_sched #(.DATA_W(DW), .TIMEOUT(8)) dut (
    .clksig (clksig),
    .rstsig (rstsig),
    .sif    (sif)
  );

  logic [4:0] strb;
  assign strb = {sif.lsig, sif.wsig, sif.esig, sif.ssig, sif.nsig};

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
  endfunction

  task automatic push_grant(input int c, input int p, input logic [DW-1:0] d);
    ev_t e;
    e.cyc    = c;
    e.strb   = 5'(1 << p);
    e.ack    = 5'(1 << p);
    e.inc    = d;
    e.commit = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_commit(input int c);
    ev_t e;
    e.cyc    = c;
    e.strb   = '0;
    e.ack    = '0;
    e.inc    = '0;
    e.commit = 1'b1;
    exp_q.push_back(e);
  endtask

  // Requesters drop req once their ack is visible.
  task automatic step();
    @(posedge clksig);
    #1;
    sif.req = sif.req & ~sif.ack;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80; i++) begin
      if (exp_q.size() == 0 && !sif.busy) break;
      step();
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_busy", sif.busy, 0);
    step();
    step();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ack"}, sif.ack, 0);
    check({tag, "_inc"}, sif.inc, 0);
    check({tag, "_strobes"}, strb, 0);
    check({tag, "_commit"}, sif.commit, 0);
    check({tag, "_busy"}, sif.busy, 0);
    check({tag, "_round_mask"}, sif.round_mask, 0);
  endtask

  // Monitor: pops one expected event per output event, checks bus idle otherwise.
  initial begin
    ev_t ev;
    forever begin
      @(negedge clksig);
      if (!rstsig) begin
        if ((|strb) || (|sif.ack) || sif.commit) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", {strb, sif.ack, sif.commit}, 0);
          end else begin
            ev = exp_q.pop_front();
            check("ev_cycle", cyc, ev.cyc);
            check("ev_strobes", strb, ev.strb);
            check("ev_ack", sif.ack, ev.ack);
            check("ev_inc", sif.inc, ev.inc);
            check("ev_commit", sif.commit, ev.commit);
          end
        end else begin
          check("idle_inc", sif.inc, 0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    sif.req    = '0;
    sif.data_n = '0;
    sif.data_s = '0;
    sif.data_e = '0;
    sif.data_w = '0;
    sif.data_l = '0;
    #1 rstsig = 1'b1;
    #2 check_zero("reset");
    step();
    step();
    rstsig = 1'b0;
    step();

    // 1: all five request together
    sif.data_n = 7'b0000101; sif.data_s = 7'b1100001; sif.data_e = 7'b0100100;
    sif.data_w = 7'b0100111; sif.data_l = 7'b1100100;
    sif.req = 5'b11111;
    b = cyc;
    push_grant(b + 1, P_N, 7'b0000101);
    push_grant(b + 2, P_S, 7'b1100001);
    push_grant(b + 3, P_E, 7'b0100100);
    push_grant(b + 4, P_W, 7'b0100111);
    push_grant(b + 5, P_L, 7'b1100100);
    push_commit(b + 6);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("t1_busy", sif.busy, (k <= 7) ? 1 : 0);
      if (k == 5) check("t1_round_mask", sif.round_mask, 5'b11111);
    end
    wait_idle();

    // 2: E and L only, round closed by the idle timer
    sif.data_e = 7'b0111111; sif.data_l = 7'b0101100;
    sif.req = 5'b10100;
    b = cyc;
    push_grant(b + 1, P_E, 7'b0111111);
    push_grant(b + 2, P_L, 7'b0101100);
    push_commit(b + 10);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 9)  check("t2_round_mask", sif.round_mask, 5'b10100);
      if (k == 12) check("t2_mask_cleared", sif.round_mask, 5'b00000);
    end
    wait_idle();

    // 3: S alone moves the pointer to E, then everyone requests
    sif.data_s = 7'b0011001;
    sif.req = 5'b00010;
    b = cyc;
    push_grant(b + 1, P_S, 7'b0011001);
    push_commit(b + 9);
    wait_idle();
    sif.data_n = 7'b1010101; sif.data_s = 7'b0110011; sif.data_e = 7'b1110000;
    sif.data_w = 7'b0001111; sif.data_l = 7'b1000001;
    sif.req = 5'b11111;
    b = cyc;
    push_grant(b + 1, P_E, 7'b1110000);
    push_grant(b + 2, P_W, 7'b0001111);
    push_grant(b + 3, P_L, 7'b1000001);
    push_grant(b + 4, P_N, 7'b1010101);
    push_grant(b + 5, P_S, 7'b0110011);
    push_commit(b + 6);
    wait_idle();

    // 4: N re-requests inside its own round and must wait for the next one
    sif.data_n = 7'b0000001; sif.data_s = 7'b0000010;
    sif.req = 5'b00011;
    b = cyc;
    push_grant(b + 1, P_N, 7'b0000001);
    push_grant(b + 2, P_S, 7'b0000010);
    push_commit(b + 10);
    push_grant(b + 13, P_N, 7'b0010101);
    push_commit(b + 21);
    step();
    step();
    sif.data_n = 7'b0010101;
    sif.req[0] = 1'b1;
    wait_idle();

    // 5: reset mid-LOAD after two grants
    sif.data_n = 7'b0000101; sif.data_s = 7'b1100001; sif.data_e = 7'b0100100;
    sif.data_w = 7'b0100111; sif.data_l = 7'b1100100;
    sif.req = 5'b11111;
    b = cyc;
    push_grant(b + 1, P_S, 7'b1100001);
    push_grant(b + 2, P_E, 7'b0100100);
    step();
    step();
    @(negedge clksig);
    #2 rstsig = 1'b1;
    #1 check_zero("midreset");
    step();
    step();
    step();
    check_zero("held_reset");
    sif.req = 5'b11111;
    rstsig = 1'b0;
    b = cyc;
    push_grant(b + 1, P_N, 7'b0000101);
    push_grant(b + 2, P_S, 7'b1100001);
    push_grant(b + 3, P_E, 7'b0100100);
    push_grant(b + 4, P_W, 7'b0100111);
    push_grant(b + 5, P_L, 7'b1100100);
    push_commit(b + 6);
    wait_idle();

    // 6: S withdraws before its turn
    sif.data_n = 7'b1111111; sif.data_s = 7'b0101010; sif.data_e = 7'b1000000;
    sif.req = 5'b00111;
    b = cyc;
    push_grant(b + 1, P_N, 7'b1111111);
    push_grant(b + 2, P_E, 7'b1000000);
    push_commit(b + 10);
    step();
    sif.req[1] = 1'b0;
    wait_idle();

    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_one_sched.md
Name: pipeline_one_sched

Overview:
Round-robin scheduler that shares the single 7-bit `inc` load bus of `pipeline_one` among five requesters: north, south, east, west and local.
- Each requester presents a flit with a req/ack handshake.
- The scheduler serialises the granted flits onto `inc`, with the matching one-hot load strobe (`nsig`/`ssig`/`esig`/`wsig`/`lsig`).
- It then issues a one-cycle commit pulse that drives `pipeline_one`'s `clksig` input, moving the round into the pipeline.
- Sits directly in front of `pipeline_one` in the router top level.

Parameters:
- DATA_W, 7, flit width on `inc` and on each `data_*` input.
- TIMEOUT, 8, idle LOAD cycles (no grant) before a partial round is committed; legal range is TIMEOUT >= 1.

Ports:
- clksig  in  1  system clock, rising edge.
- rstsig  in  1  asynchronous, active-high reset.
- req  in  5  request per port; bit order {L,W,E,S,N}, bit0 = N.
- data_n, data_s, data_e, data_w, data_l  in  DATA_W each  flit per port; held stable while its req is high.
- ack  out  5  one-cycle grant acknowledge, same bit order as `req`.
- inc  out  DATA_W  shared load bus to `pipeline_one`.
- nsig, ssig, esig, wsig, lsig  out  1 each  one-hot load strobes to `pipeline_one`.
- commit  out  1  one-cycle pulse, wired to `pipeline_one.clksig`.
- busy  out  1  high whenever the FSM is not in IDLE.
- round_mask  out  5  ports already served in the current round.

Behaviour:
- Reset (asynchronous, immediate):
  - All outputs go to 0: ack, inc, strobes, commit, busy, round_mask.
  - FSM goes to IDLE, round-robin pointer goes to N (0), timer goes to 0.
  - Any in-flight strobe is dropped and no commit is issued.
- Output timing: all outputs are registered. A grant decided from `req` in cycle t appears as strobe + ack + `inc` in cycle t+1 (latency 1).
- Eligibility: eligible = `req` & ~served. The winner is the first eligible port scanning upward from the pointer, wrapping L->N. After a grant, pointer = winner+1 mod 5.
- Grant cycle outputs: exactly one strobe high, the matching ack bit high, `inc` = that port's data. In non-grant cycles strobes and ack are 0 and `inc` holds 0.
- Requester handshake:
  - The requester holds req/data until it sees ack, and may drop req the cycle after ack.
  - Because the served bit is set at the same edge as ack, a held req cannot be re-granted within the round.
- FSM states:
  - IDLE: if any req, grant (registered next cycle) -> LOAD.
  - LOAD: grant one eligible port per cycle; timer resets on each grant and increments otherwise.
    - Go to COMMIT when served == 5'b11111, or when timer == TIMEOUT-1 with served != 0.
  - COMMIT: commit = 1 for one cycle; strobes and ack = 0 -> GAP.
  - GAP: commit = 0; clear served and timer -> IDLE.
    - The pointer is not reset here; fairness carries across rounds.
- Last flit vs commit: the last strobe of a round and commit are never in the same cycle; commit is at least one cycle after the last strobe.
- Boundary cases:
  - req from an already-served port: waits for the next round and wins the first grant there if it is the highest-priority eligible port.
  - req withdrawn before grant: no ack and no strobe for that port.
  - All five requesting together: five consecutive grant cycles, no timer involvement.
  - Timer width: clog2(TIMEOUT+1); the timer saturates and never wraps.
  - `round_mask` mirrors served and is registered.

Decomposition:
- Shared package `pipeline_pkg` holds:
  - Port index constants P_N=0 .. P_L=4 and NPORTS = 5.
  - The FSM state enum {IDLE, LOAD, COMMIT, GAP}.
  - DATA_W default.
- Sub-module `rr_pick5` (combinational): inputs eligible[4:0] and ptr[2:0]; outputs a one-hot winner and its index.

Test Plan:
1. Reset, then `req`=11111 with data_n=0000101, data_s=1100001, data_e=0100100, data_w=0100111, data_l=1100100 -> strobes N,S,E,W,L in cycles 1..5 with matching `inc`; commit in cycle 6; busy high cycles 1..7; round_mask reaches 11111.
2. Only E (0111111) and L (0101100) request -> E at cycle 1, L at cycle 2; after 8 idle LOAD cycles, commit; round_mask = 10100 before clear.
3. Round 1 only S -> pointer moves to E. Round 2 all request -> grant order E, W, L, N, S.
4. N re-raises req right after its ack in the same round -> not granted until after GAP; N granted in the first grant cycle of the next round.
5. Assert rstsig mid-LOAD after 2 grants -> all outputs 0 immediately, no commit pulse. After release with `req`=11111, first grant is N.
6. S withdraws req before its turn while N and E request -> grants N then E only; ack[1] never asserted.
